// File: rtl/alu_writeback_pkg.sv
// Shared types and encodings for the ALU result write-back stage.
package alu_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR_A = 2'd1,
    ST_WR_B = 2'd2
  } wb_state_e;

  // in_wr codes; 3 behaves like WR_SWAP
  localparam logic [1:0] WR_NONE   = 2'd0;
  localparam logic [1:0] WR_A_ONLY = 2'd1;
  localparam logic [1:0] WR_SWAP   = 2'd2;

  localparam logic [1:0] SR_NONE = 2'd0;
  localparam logic [1:0] SR_LOAD = 2'd1;
  localparam logic [1:0] SR_XOR  = 2'd2;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_W = 3;

endpackage

// File: rtl/alu_writeback_status_reg.sv
// {C,S,Z} status register: per-flag masked update, load or XOR from the
// status operand, and jump predicates derived from the stored flags only.
module alu_writeback_status_reg
  import alu_writeback_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              upd_i,
  input  logic [FLAG_W-1:0] fmask_i,
  input  logic [FLAG_W-1:0] flags_i,
  input  logic [1:0]        sr_op_i,
  input  logic [FLAG_W-1:0] sr_val_i,
  output logic [FLAG_W-1:0] status_o,
  output logic              cond_z_o,
  output logic              cond_s_o,
  output logic              cond_zs_o
);

  logic [FLAG_W-1:0] status_q;
  logic [FLAG_W-1:0] status_d;
  logic [FLAG_W-1:0] masked_upd;

  genvar gi;
  generate
    for (gi = 0; gi < FLAG_W; gi++) begin : g_mask
      assign masked_upd[gi] = fmask_i[gi] ? flags_i[gi] : status_q[gi];
    end
  endgenerate

  // Status-register ops take priority over the flag mask
  always_comb begin
    status_d = status_q;
    if (upd_i) begin
      case (sr_op_i)
        SR_LOAD: status_d = sr_val_i;
        SR_XOR:  status_d = status_q ^ sr_val_i;
        SR_NONE: status_d = masked_upd;
        default: status_d = masked_upd;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o  = status_q;
  assign cond_z_o  = status_q[FLAG_Z];
  assign cond_s_o  = status_q[FLAG_S];
  assign cond_zs_o = status_q[FLAG_Z] | status_q[FLAG_S];

endmodule

// File: rtl/alu_writeback.sv
// Accepts one ALU result per handshake, issues zero, one or two registered
// register-file write beats, and maintains the {C,S,Z} status flags.
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int WORD_W = 20,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mode,
  input  logic [WORD_W-1:0] in_res_a,
  input  logic [WORD_W-1:0] in_res_b,
  input  logic [ADDR_W-1:0] in_dst_a,
  input  logic [ADDR_W-1:0] in_dst_b,
  input  logic [1:0]        in_wr,
  input  logic              in_zero,
  input  logic              in_sign,
  input  logic              in_carry,
  input  logic [2:0]        in_fmask,
  input  logic [1:0]        in_sr_op,
  input  logic [2:0]        in_sr_val,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [WORD_W-1:0] wb_data,
  output logic [2:0]        status,
  output logic              cond_z,
  output logic              cond_s,
  output logic              cond_zs
);

  localparam int HALF_W = WORD_W / 2;
  localparam logic [WORD_W-1:0] HALF_MASK = {{(WORD_W-HALF_W){1'b0}}, {HALF_W{1'b1}}};

  wb_state_e         state_q, state_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [WORD_W-1:0] wb_data_q, wb_data_d;
  logic [ADDR_W-1:0] dst_b_q, dst_b_d;
  logic [WORD_W-1:0] res_b_q, res_b_d;
  logic              swap_q, swap_d;

  logic              transfer;
  logic [WORD_W-1:0] res_a_m;
  logic [WORD_W-1:0] res_b_m;
  logic [2:0]        flags;

  // Gating with rst_n keeps in_ready low during reset while still allowing
  // a transfer on the very first edge after release.
  assign in_ready = rst_n && (state_q == ST_IDLE);
  assign transfer = in_valid && in_ready;

  // Half-word masking is applied at capture so the write beats need no mode
  assign res_a_m = in_mode ? in_res_a : (in_res_a & HALF_MASK);
  assign res_b_m = in_mode ? in_res_b : (in_res_b & HALF_MASK);

  assign flags = {in_carry, in_sign, in_zero};

  always_comb begin
    state_d    = state_q;
    wb_valid_d = wb_valid_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    dst_b_d    = dst_b_q;
    res_b_d    = res_b_q;
    swap_d     = swap_q;
    case (state_q)
      ST_IDLE: begin
        if (transfer && (in_wr != WR_NONE)) begin
          state_d    = ST_WR_A;
          wb_valid_d = 1'b1;
          wb_addr_d  = in_dst_a;
          wb_data_d  = res_a_m;
          dst_b_d    = in_dst_b;
          res_b_d    = res_b_m;
          swap_d     = (in_wr != WR_A_ONLY);
        end
      end
      ST_WR_A: begin
        if (wb_ready) begin
          if (swap_q) begin
            state_d   = ST_WR_B;
            wb_addr_d = dst_b_q;
            wb_data_d = res_b_q;
          end else begin
            state_d    = ST_IDLE;
            wb_valid_d = 1'b0;
          end
        end
      end
      ST_WR_B: begin
        if (wb_ready) begin
          state_d    = ST_IDLE;
          wb_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        wb_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      dst_b_q    <= '0;
      res_b_q    <= '0;
      swap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wb_valid_q <= wb_valid_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      dst_b_q    <= dst_b_d;
      res_b_q    <= res_b_d;
      swap_q     <= swap_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

  alu_writeback_status_reg u_status_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .upd_i     (transfer),
    .fmask_i   (in_fmask),
    .flags_i   (flags),
    .sr_op_i   (in_sr_op),
    .sr_val_i  (in_sr_val),
    .status_o  (status),
    .cond_z_o  (cond_z),
    .cond_s_o  (cond_s),
    .cond_zs_o (cond_zs)
  );

endmodule

// File: tb/tb_alu_writeback.sv
// Directed bench for alu_writeback: expected write beats are queued when a
// result is sent and checked against every valid cycle of the write port.
module tb_alu_writeback;

  localparam int WORD_W = 20;
  localparam int ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [WORD_W-1:0] in_res_a;
  logic [WORD_W-1:0] in_res_b;
  logic [ADDR_W-1:0] in_dst_a;
  logic [ADDR_W-1:0] in_dst_b;
  logic [1:0]        in_wr;
  logic              in_zero;
  logic              in_sign;
  logic              in_carry;
  logic [2:0]        in_fmask;
  logic [1:0]        in_sr_op;
  logic [2:0]        in_sr_val;
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [WORD_W-1:0] wb_data;
  logic [2:0]        status;
  logic              cond_z;
  logic              cond_s;
  logic              cond_zs;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  alu_writeback #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_res_a  (in_res_a),
    .in_res_b  (in_res_b),
    .in_dst_a  (in_dst_a),
    .in_dst_b  (in_dst_b),
    .in_wr     (in_wr),
    .in_zero   (in_zero),
    .in_sign   (in_sign),
    .in_carry  (in_carry),
    .in_fmask  (in_fmask),
    .in_sr_op  (in_sr_op),
    .in_sr_val (in_sr_val),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .status    (status),
    .cond_z    (cond_z),
    .cond_s    (cond_s),
    .cond_zs   (cond_zs)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Every valid cycle must match the queue head; a handshake retires it.
  always @(negedge clk) begin
    if (rst_n && wb_valid) begin
      total++;
      assert ((exp_q.size() > 0) === 1'b1) else begin
        bad++;
        $error("FAIL unexpected_beat observed addr=%0h data=%0h expected=no_beat", wb_addr, wb_data);
      end
      if (exp_q.size() > 0) begin
        total++;
        assert ({wb_addr, wb_data} === {exp_q[0].addr, exp_q[0].data}) else begin
          bad++;
          $error("FAIL beat observed=(%0h,%0h) expected=(%0h,%0h)",
                 wb_addr, wb_data, exp_q[0].addr, exp_q[0].data);
        end
        if (wb_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WORD_W-1:0] wmask(input logic mode, input logic [WORD_W-1:0] v);
    logic [WORD_W-1:0] m;
    m = mode ? {WORD_W{1'b1}} : {{(WORD_W/2){1'b0}}, {(WORD_W/2){1'b1}}};
    return v & m;
  endfunction

  // Called just after a posedge; returns just after the transfer edge.
  task automatic send(input logic mode, input logic [WORD_W-1:0] ra, input logic [WORD_W-1:0] rb,
                      input logic [ADDR_W-1:0] da, input logic [ADDR_W-1:0] db,
                      input logic [1:0] wr, input logic [2:0] flg, input logic [2:0] fm,
                      input logic [1:0] sop, input logic [2:0] sval);
    int n = 0;
    in_mode = mode; in_res_a = ra; in_res_b = rb; in_dst_a = da; in_dst_b = db;
    in_wr = wr; in_zero = flg[0]; in_sign = flg[1]; in_carry = flg[2];
    in_fmask = fm; in_sr_op = sop; in_sr_val = sval;
    in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", (n < 20), 1);
    if (wr != 2'd0) exp_q.push_back('{addr: da, data: wmask(mode, ra)});
    if (wr >= 2'd2) exp_q.push_back('{addr: db, data: wmask(mode, rb)});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; wb_ready = 1'b0;
    in_mode = 1'b1; in_res_a = '0; in_res_b = '0; in_dst_a = '0; in_dst_b = '0;
    in_wr = 2'd0; in_zero = 1'b0; in_sign = 1'b0; in_carry = 1'b0;
    in_fmask = 3'b000; in_sr_op = 2'd0; in_sr_val = 3'b000;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_status", status, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_wb_data", wb_data, 0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1);

    // Compare that sets Z, so the next full-word write visibly clears it
    send(1'b1, 20'h0, 20'h0, 4'd0, 4'd0, 2'd0, 3'b001, 3'b001, 2'd0, 3'b000);
    chk("cmp_status_z", status, 3'b001);

    wb_ready = 1'b1;
    send(1'b1, 20'hABCDE, 20'h0, 4'd3, 4'd0, 2'd1, 3'b000, 3'b001, 2'd0, 3'b000);
    chk("full_status", status, 3'b000);
    chk("full_cond_z", cond_z, 0);
    @(posedge clk); #1;
    chk("full_done_valid", wb_valid, 0);
    chk("full_done_ready", in_ready, 1);

    send(1'b0, 20'hFFFFF, 20'h0, 4'd5, 4'd0, 2'd1, 3'b111, 3'b000, 2'd0, 3'b000);
    chk("half_status_hold", status, 3'b000);
    @(posedge clk); #1;

    // Swap with the write port stalled for three cycles
    wb_ready = 1'b0;
    send(1'b1, 20'd5, 20'd9, 4'd1, 4'd2, 2'd2, 3'b000, 3'b000, 2'd0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", wb_valid, 1);
      @(posedge clk); #1;
    end
    wb_ready = 1'b1;
    chk("swap_a_in_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("swap_b_in_ready", in_ready, 0);
    chk("swap_b_addr", wb_addr, 2);
    @(posedge clk); #1;
    chk("swap_done_ready", in_ready, 1);
    chk("swap_done_valid", wb_valid, 0);

    // Half-word swap using code 3 with dirty upper bits on both results
    send(1'b0, 20'h12345, 20'hFEDCB, 4'd7, 4'd8, 2'd3, 3'b000, 3'b000, 2'd0, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    chk("swap3_done_ready", in_ready, 1);

    // Load overrides fmask, then XOR, then load zero
    send(1'b1, 20'h0, 20'h0, 4'd0, 4'd0, 2'd0, 3'b010, 3'b111, 2'd1, 3'b101);
    chk("load_status", status, 3'b101);
    chk("load_cond_z", cond_z, 1);
    chk("load_cond_s", cond_s, 0);
    chk("load_cond_zs", cond_zs, 1);
    chk("load_one_cycle", in_ready, 1);
    send(1'b1, 20'h0, 20'h0, 4'd0, 4'd0, 2'd0, 3'b111, 3'b111, 2'd2, 3'b011);
    chk("xor_status", status, 3'b110);
    chk("xor_cond_z", cond_z, 0);
    chk("xor_cond_s", cond_s, 1);
    chk("xor_cond_zs", cond_zs, 1);
    send(1'b1, 20'h0, 20'h0, 4'd0, 4'd0, 2'd0, 3'b111, 3'b111, 2'd1, 3'b000);
    chk("load0_status", status, 3'b000);
    chk("load0_cond_zs", cond_zs, 0);
    chk("load0_cond_s", cond_s, 0);

    // Back-to-back compares, carry masked off
    in_mode = 1'b1; in_wr = 2'd0; in_zero = 1'b1; in_sign = 1'b1; in_carry = 1'b1;
    in_fmask = 3'b011; in_sr_op = 2'd0; in_sr_val = 3'b000;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_status", status, 3'b011);
    chk("b2b_valid", wb_valid, 0);

    // wb_ready while idle must not create a beat
    wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("idle_ready_valid", wb_valid, 0);
      @(posedge clk); #1;
    end

    // Reset while the second swap beat is pending
    send(1'b1, 20'h0, 20'h0, 4'd0, 4'd0, 2'd0, 3'b000, 3'b000, 2'd1, 3'b111);
    chk("pre_rst_status", status, 3'b111);
    wb_ready = 1'b0;
    send(1'b1, 20'h11111, 20'h22222, 4'd4, 4'd9, 2'd2, 3'b000, 3'b000, 2'd0, 3'b000);
    wb_ready = 1'b1;
    exp_q.delete(1);
    @(posedge clk); #1;
    wb_ready = 1'b0;
    chk("wrb_valid", wb_valid, 1);
    chk("wrb_addr", wb_addr, 9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", wb_valid, 0);
    chk("async_rst_status", status, 0);
    chk("async_rst_ready", in_ready, 0);
    chk("async_rst_addr", wb_addr, 0);
    chk("async_rst_data", wb_data, 0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_beat", wb_valid, 0);
      @(posedge clk); #1;
    end

    send(1'b1, 20'h0F0F0, 20'h0, 4'd6, 4'd0, 2'd1, 3'b000, 3'b000, 2'd0, 3'b000);
    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
